// File: rtl/prog_seq_pkg.sv
// Shared state encoding and default parameters for the program run sequencer.
package prog_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RESET_CORE,
    START,
    RUN,
    DONE
  } seq_state_t;

  localparam int DEF_NUM_PROGS      = 3;
  localparam int DEF_RESET_CYCLES   = 2;
  localparam int DEF_START_CYCLES   = 1;
  localparam int DEF_CNT_W          = 16;
  localparam int DEF_TIMEOUT_CYCLES = 16'hFFFF;

endpackage

// File: rtl/prog_sequencer_cycle_timer.sv
// Up-counter with synchronous clear (priority over enable) and equality compare against term.
// hit is combinational from the registered count; no flow control.
module cycle_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] term,
  output logic [CNT_W-1:0] count,
  output logic             hit
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

  assign hit = (count == term);

endmodule

// File: rtl/prog_sequencer.sv
// Drives core Reset/Start, times each run until CoreAck or timeout, optionally auto-runs all programs.
// Outputs decode from registered state only; Go is taken in IDLE alone, Abort wins everywhere.
module prog_sequencer
  import prog_seq_pkg::*;
#(
  parameter int NUM_PROGS      = DEF_NUM_PROGS,
  parameter int RESET_CYCLES   = DEF_RESET_CYCLES,
  parameter int START_CYCLES   = DEF_START_CYCLES,
  parameter int CNT_W          = DEF_CNT_W,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int PW             = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Go,
  input  logic             RunAll,
  input  logic [PW-1:0]    ProgSel,
  input  logic             Abort,
  input  logic             CoreAck,
  output logic             CoreReset,
  output logic             CoreStart,
  output logic [PW-1:0]    ProgIdx,
  output logic             Busy,
  output logic             Done,
  output logic             Timeout,
  output logic [CNT_W-1:0] CycleCount
);

  localparam logic [PW-1:0]    LAST_IDX  = PW'(NUM_PROGS - 1);
  localparam logic [CNT_W-1:0] RST_TERM  = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] STRT_TERM = CNT_W'(START_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_TERM   = CNT_W'(TIMEOUT_CYCLES);

  seq_state_t       state;
  seq_state_t       next_state;
  logic             mode_all;
  logic             tmr_clr;
  logic             tmr_hit;
  logic [CNT_W-1:0] tmr_term;
  logic [CNT_W-1:0] tmr_cnt;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    if (Abort) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:       if (Go) next_state = RESET_CORE;
        RESET_CORE: if (tmr_hit) next_state = START;
        START:      if (tmr_hit) next_state = RUN;
        RUN:        if (CoreAck || tmr_hit) next_state = DONE;
        DONE:       next_state = (mode_all && (ProgIdx < LAST_IDX)) ? RESET_CORE : IDLE;
        default:    next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    CoreReset = 1'b1;
    CoreStart = 1'b0;
    Busy      = 1'b1;
    Done      = 1'b0;
    case (state)
      IDLE:       Busy = 1'b0;
      RESET_CORE: CoreReset = 1'b1;
      START: begin
        CoreReset = 1'b0;
        CoreStart = 1'b1;
      end
      RUN:        CoreReset = 1'b0;
      DONE:       Done = 1'b1;
      default:    Busy = 1'b0;
    endcase
  end

  // One timer serves every phase: the dwell terms are N-1 because the count starts at 0 on entry.
  always_comb begin
    tmr_term = '1;
    case (state)
      RESET_CORE: tmr_term = RST_TERM;
      START:      tmr_term = STRT_TERM;
      RUN:        tmr_term = TO_TERM;
      default:    tmr_term = '1;
    endcase
  end

  assign tmr_clr = (next_state != state) || (state == IDLE) || (state == DONE);

  cycle_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk   (Clk),
    .rst_n (Reset_n),
    .clr   (tmr_clr),
    .en    (1'b1),
    .term  (tmr_term),
    .count (tmr_cnt),
    .hit   (tmr_hit)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ProgIdx    <= '0;
      mode_all   <= 1'b0;
      CycleCount <= '0;
      Timeout    <= 1'b0;
    end else begin
      if ((state == IDLE) && Go && !Abort) begin
        mode_all <= RunAll;
        if (RunAll) begin
          ProgIdx <= '0;
        end else begin
          ProgIdx <= (ProgSel > LAST_IDX) ? LAST_IDX : ProgSel;
        end
      end
      // Ack outranks the timeout compare when both land in the same cycle.
      if ((state == RUN) && (next_state == DONE)) begin
        CycleCount <= tmr_cnt;
        Timeout    <= !CoreAck;
      end
      if ((state == DONE) && (next_state == RESET_CORE)) begin
        ProgIdx <= ProgIdx + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_prog_sequencer.sv
// Randomized bench for prog_sequencer: the bench plays the core and predicts each run from delay rules.
module tb_prog_sequencer;

  localparam int NUM_PROGS = 3;
  localparam int RST_CYC   = 2;
  localparam int STRT_CYC  = 1;
  localparam int CNT_W     = 16;
  localparam int TO        = 50;
  localparam int PW        = 2;

  logic             Clk = 1'b0;
  logic             Reset_n;
  logic             Go;
  logic             RunAll;
  logic [PW-1:0]    ProgSel;
  logic             Abort;
  logic             CoreAck;
  logic             CoreReset;
  logic             CoreStart;
  logic [PW-1:0]    ProgIdx;
  logic             Busy;
  logic             Done;
  logic             Timeout;
  logic [CNT_W-1:0] CycleCount;

  int n_checks = 0;
  int n_errs   = 0;
  int dly[NUM_PROGS];
  int last_cc  = 0;
  bit last_to  = 1'b0;
  bit go_noise = 1'b0;

  prog_sequencer #(
    .NUM_PROGS(NUM_PROGS), .RESET_CYCLES(RST_CYC), .START_CYCLES(STRT_CYC),
    .CNT_W(CNT_W), .TIMEOUT_CYCLES(TO)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Go(Go), .RunAll(RunAll), .ProgSel(ProgSel),
    .Abort(Abort), .CoreAck(CoreAck), .CoreReset(CoreReset), .CoreStart(CoreStart),
    .ProgIdx(ProgIdx), .Busy(Busy), .Done(Done), .Timeout(Timeout), .CycleCount(CycleCount)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_core_reset"}, CoreReset, 1);
    check({tag, "_core_start"}, CoreStart, 0);
    check({tag, "_busy"}, Busy, 0);
    check({tag, "_done"}, Done, 0);
    check({tag, "_timeout"}, Timeout, 0);
    check({tag, "_cycle_count"}, CycleCount, 0);
    check({tag, "_prog_idx"}, ProgIdx, 0);
  endtask

  // Reference rules: ack d cycles into RUN gives CycleCount=d unless d exceeds TO (then TO, Timeout=1).
  task automatic run_job(input bit run_all, input int sel, input int abort_at, input int rst_at);
    int idx, last, rc, sc, cyc, d, exp_cc;
    bit timed_out;
    idx  = run_all ? 0 : ((sel >= NUM_PROGS) ? NUM_PROGS - 1 : sel);
    last = run_all ? NUM_PROGS - 1 : idx;
    RunAll = run_all; ProgSel = PW'(sel); Go = 1'b1;
    tick();
    Go = 1'b0; RunAll = 1'($urandom); ProgSel = PW'($urandom);
    check("busy_after_go", Busy, 1);
    check("prog_idx_load", ProgIdx, idx);
    for (int p = idx; p <= last; p++) begin
      rc = 0;
      while (CoreReset && !CoreStart && rc < 20) begin rc++; tick(); end
      check("reset_len", rc, RST_CYC);
      sc = 0;
      while (CoreStart && !CoreReset && sc < 20) begin sc++; tick(); end
      check("start_len", sc, STRT_CYC);
      d = dly[p];
      cyc = 0;
      while (Done !== 1'b1 && cyc <= TO + 5) begin
        if (p == idx && cyc == abort_at) begin
          Go = 1'b0; Abort = 1'b1;
          tick();
          Abort = 1'b0;
          check("abort_busy", Busy, 0);
          check("abort_no_done", Done, 0);
          check("abort_core_reset", CoreReset, 1);
          check("abort_cc_kept", CycleCount, last_cc);
          check("abort_to_kept", Timeout, last_to);
          tick();
          check("abort_still_idle", Busy, 0);
          return;
        end
        if (p == idx && cyc == rst_at) begin
          Go = 1'b0;
          #2 Reset_n = 1'b0;
          #1 check_reset_vals("async_rst");
          last_cc = 0; last_to = 1'b0;
          #2 Reset_n = 1'b1;
          tick();
          check("post_rst_idle", Busy, 0);
          return;
        end
        CoreAck = (cyc == d);
        Go = go_noise ? 1'($urandom) : 1'b0;
        tick();
        cyc++;
      end
      CoreAck = 1'b0; Go = 1'b0;
      timed_out = (d < 0) || (d > TO);
      exp_cc = timed_out ? TO : d;
      check("done_pulse", Done, 1);
      check("run_len", cyc, exp_cc + 1);
      check("cycle_count", CycleCount, exp_cc);
      check("timeout", Timeout, timed_out);
      check("prog_idx_run", ProgIdx, p);
      last_cc = exp_cc; last_to = timed_out;
      tick();
      check("done_one_cycle", Done, 0);
      check("busy_after_done", Busy, (p < last));
    end
    check("idle_prog_idx", ProgIdx, last);
    check("idle_cc_hold", CycleCount, last_cc);
  endtask

  initial begin
    Reset_n = 1'b0; Go = 1'b0; RunAll = 1'b0; ProgSel = '0; Abort = 1'b0; CoreAck = 1'b0;
    foreach (dly[i]) dly[i] = 0;
    #3 check_reset_vals("reset");
    #10 Reset_n = 1'b1;
    tick();

    dly[1] = 37;
    run_job(1'b0, 1, -1, -1);

    dly[0] = 10; dly[1] = 20; dly[2] = 30;
    run_job(1'b1, 0, -1, -1);

    dly[0] = -1;
    run_job(1'b0, 0, -1, -1);
    dly[2] = TO;
    run_job(1'b0, 2, -1, -1);

    dly[1] = -1;
    run_job(1'b0, 1, 12, -1);
    Go = 1'b1; Abort = 1'b1;
    tick();
    Go = 1'b0; Abort = 1'b0;
    check("go_with_abort_idle", Busy, 0);
    tick();
    check("go_with_abort_idle2", Busy, 0);

    go_noise = 1'b1;
    dly[0] = 25;
    run_job(1'b0, 0, -1, 7);
    dly[0] = 25;
    run_job(1'b0, 0, -1, -1);

    dly[2] = 5;
    run_job(1'b0, 3, -1, -1);

    for (int i = 0; i < 10; i++) begin
      foreach (dly[p]) dly[p] = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, TO + 10));
      run_job(1'($urandom), int'($urandom_range(0, 3)), -1, -1);
      repeat ($urandom_range(0, 3)) tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
